// File: rtl/pistorm_pkg.sv
// -----------------------------------------------------------------------------
// pistorm_pkg
// Shared types and constants for the PiStorm 68000 bus-mastership logic.
//   arb_state_t           : bus arbiter states
//   DEF_*                 : default parameter values for m68k_bus_arbiter
//   STATUS_EXT_OWNER_BIT  : position of ext_owner in the host status register
// -----------------------------------------------------------------------------
package pistorm_pkg;

  typedef enum logic [1:0] {
    OWN     = 2'd0,  // FPGA owns and drives the bus
    GRANT   = 2'd1,  // BG asserted, waiting for BGACK
    EXT     = 2'd2,  // external master holds the bus
    RECLAIM = 2'd3   // external master released, bus still tri-stated
  } arb_state_t;

  localparam int DEF_SYNC_STAGES    = 2;
  localparam int DEF_GRANT_TIMEOUT  = 16;
  localparam int DEF_RECLAIM_CYCLES = 1;

  localparam int STATUS_EXT_OWNER_BIT = 4;

endpackage

// File: rtl/pistorm_sync.sv
// -----------------------------------------------------------------------------
// pistorm_sync
// Single-bit multi-flop synchronizer for asynchronous 68000 bus signals.
// Resets to 1, the idle level of the active-low bus lines it carries.
// Ports:
//   clk   in  : destination clock
//   reset in  : synchronous active-high reset
//   d     in  : raw asynchronous input
//   q     out : synchronized output, STAGES clock cycles behind d
// -----------------------------------------------------------------------------
module pistorm_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_r;

  // Shift chain: stage 0 captures the raw input, the last stage is the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_r <= {STAGES{1'b1}};
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[STAGES-1];

endmodule

// File: rtl/m68k_bus_arbiter.sv
// -----------------------------------------------------------------------------
// m68k_bus_arbiter
// 68000 bus-mastership handshake (BR/BG/BGACK) between the Pi-driven bus-cycle
// engine and external DMA masters. Decisions are taken on 7 MHz rising edges;
// the engine starts cycles on falling edges, so bus_owned is always settled
// half a 7 MHz period before it is sampled.
// Optional build macro: M68K_ARB_FAIR_EN -- after an external tenure with a Pi
// transaction pending, the Pi gets one bus cycle before the next grant, and
// RECLAIM->GRANT chaining is suppressed while a Pi transaction is pending.
// Ports:
//   c200m         in  : system clock
//   reset         in  : synchronous active-high reset
//   c7m_rising    in  : one-cycle pulse on 7 MHz rising edge
//   c7m_falling   in  : one-cycle pulse on 7 MHz falling edge
//   M68K_BR_n     in  : raw async bus request
//   M68K_BGACK_n  in  : raw async bus grant acknowledge
//   cyc_active    in  : bus-cycle engine busy (not in S0)
//   op_pending    in  : Pi transaction waiting to start
//   M68K_BG_n     out : bus grant to external master
//   bus_owned     out : engine may start a new cycle
//   drive_en      out : FPGA drives strobes/FC/address; 0 = tri-stated
//   ext_owner     out : external master holds the bus
//   grant_timeout out : one-cycle pulse when a grant is withdrawn on timeout
// -----------------------------------------------------------------------------
module m68k_bus_arbiter
  import pistorm_pkg::*;
#(
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int GRANT_TIMEOUT  = DEF_GRANT_TIMEOUT,
  parameter int RECLAIM_CYCLES = DEF_RECLAIM_CYCLES
) (
  input  logic c200m,
  input  logic reset,
  input  logic c7m_rising,
  input  logic c7m_falling,
  input  logic M68K_BR_n,
  input  logic M68K_BGACK_n,
  input  logic cyc_active,
  input  logic op_pending,
  output logic M68K_BG_n,
  output logic bus_owned,
  output logic drive_en,
  output logic ext_owner,
  output logic grant_timeout
);

  localparam int TW = $clog2(GRANT_TIMEOUT + 1);
  localparam int RW = $clog2(RECLAIM_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(GRANT_TIMEOUT - 1);
  localparam logic [RW-1:0] R_LAST = RW'(RECLAIM_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = {TW{1'b1}};
  localparam logic [RW-1:0] R_MAX  = {RW{1'b1}};

  logic br_n_sync_s, bgack_n_sync_s;
  logic br_s, bgack_s;
  logic hold_br_s;      // suppresses honouring br while in OWN
  logic chain_block_s;  // suppresses RECLAIM->GRANT chaining

  arb_state_t    state_r, state_n;
  logic          bg_n_r, bg_n_n;
  logic          owned_r, owned_n;
  logic          drive_r, drive_n;
  logic          ext_r, ext_n;
  logic          pulse_r, pulse_n;
  logic [TW-1:0] tcnt_r, tcnt_n;
  logic [RW-1:0] rcnt_r, rcnt_n;

  pistorm_sync #(.STAGES(SYNC_STAGES)) u_sync_br (
    .clk   (c200m),
    .reset (reset),
    .d     (M68K_BR_n),
    .q     (br_n_sync_s)
  );

  pistorm_sync #(.STAGES(SYNC_STAGES)) u_sync_bgack (
    .clk   (c200m),
    .reset (reset),
    .d     (M68K_BGACK_n),
    .q     (bgack_n_sync_s)
  );

  assign br_s    = ~br_n_sync_s;
  assign bgack_s = ~bgack_n_sync_s;

`ifdef M68K_ARB_FAIR_EN
  logic owe_r, owe_n;
  logic cyc_d_r;
  logic owe_clr_s;

  // A completed engine cycle (cyc_active falling) repays the Pi.
  assign owe_clr_s     = cyc_d_r & ~cyc_active;
  assign hold_br_s     = owe_r;
  assign chain_block_s = op_pending;

  // Fairness bookkeeping registers.
  always_ff @(posedge c200m) begin
    if (reset) begin
      owe_r   <= 1'b0;
      cyc_d_r <= 1'b0;
    end else begin
      owe_r   <= owe_n;
      cyc_d_r <= cyc_active;
    end
  end

  // The engine samples bus_owned on its own; the falling pulse is not needed here.
  logic unused_s;
  assign unused_s = c7m_falling;
`else
  assign hold_br_s     = 1'b0;
  assign chain_block_s = 1'b0;

  // Inputs only consumed by the fairness option or by the engine itself.
  logic unused_s;
  assign unused_s = c7m_falling ^ op_pending;
`endif

  // Next-state and next-output logic; all decisions gated by c7m_rising.
  always_comb begin
    state_n = state_r;
    bg_n_n  = bg_n_r;
    owned_n = owned_r;
    drive_n = drive_r;
    ext_n   = ext_r;
    pulse_n = 1'b0;
    tcnt_n  = tcnt_r;
    rcnt_n  = rcnt_r;
`ifdef M68K_ARB_FAIR_EN
    if (owe_clr_s) begin
      owe_n = 1'b0;
    end else begin
      owe_n = owe_r;
    end
`endif
    if (c7m_rising) begin
      case (state_r)
        OWN: begin
          // A grant is never issued while an engine cycle is in flight.
          if (br_s && !cyc_active && !hold_br_s) begin
            state_n = GRANT;
            bg_n_n  = 1'b0;
            owned_n = 1'b0;
            tcnt_n  = {TW{1'b0}};
          end else begin
            state_n = OWN;
          end
        end
        GRANT: begin
          // BGACK beats a coincident timeout.
          if (bgack_s) begin
            state_n = EXT;
            bg_n_n  = 1'b1;
            drive_n = 1'b0;
            ext_n   = 1'b1;
          end else if (!br_s) begin
            state_n = OWN;
            bg_n_n  = 1'b1;
            owned_n = 1'b1;
            drive_n = 1'b1;
          end else if (tcnt_r == T_LAST) begin
            state_n = OWN;
            bg_n_n  = 1'b1;
            owned_n = 1'b1;
            drive_n = 1'b1;
            pulse_n = 1'b1;
          end else if (tcnt_r != T_MAX) begin
            tcnt_n = tcnt_r + TW'(1);
          end else begin
            tcnt_n = tcnt_r;
          end
        end
        EXT: begin
          if (!bgack_s) begin
            state_n = RECLAIM;
            ext_n   = 1'b0;
            rcnt_n  = {RW{1'b0}};
`ifdef M68K_ARB_FAIR_EN
            if (op_pending) begin
              owe_n = 1'b1;
            end else begin
              owe_n = owe_clr_s ? 1'b0 : owe_r;
            end
`endif
          end else begin
            state_n = EXT;
          end
        end
        RECLAIM: begin
          // Chained master: re-grant without ever re-driving the bus.
          if (br_s && !bgack_s && !chain_block_s) begin
            state_n = GRANT;
            bg_n_n  = 1'b0;
            tcnt_n  = {TW{1'b0}};
          end else if (rcnt_r == R_LAST) begin
            state_n = OWN;
            bg_n_n  = 1'b1;
            owned_n = 1'b1;
            drive_n = 1'b1;
          end else if (rcnt_r != R_MAX) begin
            rcnt_n = rcnt_r + RW'(1);
          end else begin
            rcnt_n = rcnt_r;
          end
        end
        default: begin
          state_n = OWN;
          bg_n_n  = 1'b1;
          owned_n = 1'b1;
          drive_n = 1'b1;
          ext_n   = 1'b0;
          tcnt_n  = {TW{1'b0}};
          rcnt_n  = {RW{1'b0}};
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // State, counter and output registers.
  always_ff @(posedge c200m) begin
    if (reset) begin
      state_r <= OWN;
      bg_n_r  <= 1'b1;
      owned_r <= 1'b1;
      drive_r <= 1'b1;
      ext_r   <= 1'b0;
      pulse_r <= 1'b0;
      tcnt_r  <= {TW{1'b0}};
      rcnt_r  <= {RW{1'b0}};
    end else begin
      state_r <= state_n;
      bg_n_r  <= bg_n_n;
      owned_r <= owned_n;
      drive_r <= drive_n;
      ext_r   <= ext_n;
      pulse_r <= pulse_n;
      tcnt_r  <= tcnt_n;
      rcnt_r  <= rcnt_n;
    end
  end

  assign M68K_BG_n     = bg_n_r;
  assign bus_owned     = owned_r;
  assign drive_en      = drive_r;
  assign ext_owner     = ext_r;
  assign grant_timeout = pulse_r;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_m68k_bus_arbiter
// Bench for m68k_bus_arbiter. Generates a 7 MHz-like pulse train (8 c200m
// cycles per period), changes bus inputs mid-period, and compares outputs
// against a model that tracks who holds the bus and when grants/releases
// happened (edge timestamps rather than counters).
// -----------------------------------------------------------------------------
module tb_m68k_bus_arbiter;

  localparam int GRANT_TIMEOUT  = 16;
  localparam int RECLAIM_CYCLES = 1;
`ifdef M68K_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic c200m = 1'b0;
  logic reset, c7m_rising, c7m_falling;
  logic br_n, bgack_n, cyc_active, op_pending;
  logic bg_n, bus_owned, drive_en, ext_owner, grant_timeout;

  always #5 c200m = ~c200m;

  m68k_bus_arbiter dut (
    .c200m         (c200m),
    .reset         (reset),
    .c7m_rising    (c7m_rising),
    .c7m_falling   (c7m_falling),
    .M68K_BR_n     (br_n),
    .M68K_BGACK_n  (bgack_n),
    .cyc_active    (cyc_active),
    .op_pending    (op_pending),
    .M68K_BG_n     (bg_n),
    .bus_owned     (bus_owned),
    .drive_en      (drive_en),
    .ext_owner     (ext_owner),
    .grant_timeout (grant_timeout)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pulses_seen = 0;
  int pulses_exp  = 0;

  // Count every timeout pulse the DUT emits.
  always @(posedge c200m) begin
    if (grant_timeout) pulses_seen <= pulses_seen + 1;
  end

  // ---------------- reference model ----------------
  typedef enum int {H_PI, H_OFFER, H_DMA, H_SETTLE} holder_t;
  holder_t holder = H_PI;
  int  edge_no = 0;
  int  offer_edge = 0;
  int  settle_edge = 0;
  bit  offer_from_pi = 1'b1;  // grant offered while FPGA still drives the bus
  bit  owe = 1'b0;
  bit  m_br = 1'b0, m_bgack = 1'b0, m_cyc = 1'b0, m_op = 1'b0;

  task automatic check_eq(input string tag, input int got, input int expected);
    n_checks++;
    if (got == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, expected);
  endtask

  task automatic model_reset();
    holder = H_PI;
    owe    = 1'b0;
  endtask

  // One 7 MHz rising edge as seen by the bus protocol.
  task automatic model_step();
    edge_no++;
    case (holder)
      H_PI: begin
        if (m_br && !m_cyc && !owe) begin
          holder = H_OFFER; offer_edge = edge_no; offer_from_pi = 1'b1;
        end
      end
      H_OFFER: begin
        if (m_bgack) holder = H_DMA;
        else if (!m_br) holder = H_PI;
        else if (edge_no - offer_edge == GRANT_TIMEOUT) begin
          holder = H_PI; pulses_exp++;
        end
      end
      H_DMA: begin
        if (!m_bgack) begin
          holder = H_SETTLE; settle_edge = edge_no;
          if (FAIR && m_op) owe = 1'b1;
        end
      end
      H_SETTLE: begin
        if (m_br && !m_bgack && !(FAIR && m_op)) begin
          holder = H_OFFER; offer_edge = edge_no; offer_from_pi = 1'b0;
        end else if (edge_no - settle_edge >= RECLAIM_CYCLES) holder = H_PI;
      end
      default: holder = H_PI;
    endcase
  endtask

  task automatic check_outputs(input string ctx);
    check_eq({ctx, ":bg_n"},      int'(bg_n),      int'(holder != H_OFFER));
    check_eq({ctx, ":bus_owned"}, int'(bus_owned), int'(holder == H_PI));
    check_eq({ctx, ":drive_en"},  int'(drive_en),
             int'(holder == H_PI || (holder == H_OFFER && offer_from_pi)));
    check_eq({ctx, ":ext_owner"}, int'(ext_owner), int'(holder == H_DMA));
    check_eq({ctx, ":timeouts"},  pulses_seen,     pulses_exp);
  endtask

  task automatic set_inputs(input bit br, input bit bgack, input bit cyc, input bit op);
    if (m_cyc && !cyc) owe = 1'b0;
    m_br = br; m_bgack = bgack; m_cyc = cyc; m_op = op;
    br_n = ~br; bgack_n = ~bgack; cyc_active = cyc; op_pending = op;
  endtask

  // One 7 MHz period: decide on rising, check mid-high, then apply next inputs.
  task automatic period(input bit br, input bit bgack, input bit cyc, input bit op,
                        input string ctx);
    for (int ph = 0; ph < 8; ph++) begin
      c7m_rising  = (ph == 0);
      c7m_falling = (ph == 4);
      if (ph == 0) model_step();
      if (ph == 3) check_outputs(ctx);
      if (ph == 4) set_inputs(br, bgack, cyc, op);
      @(posedge c200m); #1;
    end
  endtask

  task automatic reset_now(input string ctx);
    c7m_rising = 1'b0; c7m_falling = 1'b0;
    reset = 1'b1;
    model_reset();
    @(posedge c200m); #1;
    check_outputs(ctx);
    reset = 1'b0;
    repeat (3) begin @(posedge c200m); #1; end
  endtask

  initial begin
    reset = 1'b1; c7m_rising = 1'b0; c7m_falling = 1'b0;
    set_inputs(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (4) begin @(posedge c200m); #1; end
    check_outputs("reset");
    reset = 1'b0;
    repeat (3) begin @(posedge c200m); #1; end

    // Idle arbitration, release and reclaim.
    period(1'b1, 1'b0, 1'b0, 1'b0, "idle_req");
    period(1'b1, 1'b1, 1'b0, 1'b0, "idle_grant");
    period(1'b1, 1'b1, 1'b0, 1'b0, "idle_ext");
    period(1'b0, 1'b0, 1'b0, 1'b0, "idle_ext2");
    period(1'b0, 1'b0, 1'b0, 1'b0, "idle_reclaim");
    period(1'b0, 1'b0, 1'b0, 1'b0, "idle_own");

    // Request while an engine cycle is in flight.
    for (int i = 0; i < 4; i++) period(1'b1, 1'b0, 1'b1, 1'b1, "inflight");
    period(1'b1, 1'b0, 1'b0, 1'b0, "inflight_end");
    period(1'b1, 1'b0, 1'b0, 1'b0, "inflight_grant");

    // Grant never acknowledged: timeout (already in GRANT, keep requesting).
    for (int i = 0; i < GRANT_TIMEOUT + 2; i++) period(1'b1, 1'b0, 1'b0, 1'b0, "timeout");
    period(1'b0, 1'b0, 1'b0, 1'b0, "timeout_done");

    // Withdrawn request.
    for (int i = 0; i < 3; i++) period(1'b1, 1'b0, 1'b0, 1'b0, "withdraw");
    period(1'b0, 1'b0, 1'b0, 1'b0, "withdraw_rel");
    period(1'b0, 1'b0, 1'b0, 1'b0, "withdraw_own");

    // Chained masters: BR held across BGACK negation.
    period(1'b1, 1'b0, 1'b0, 1'b0, "chain_req");
    period(1'b1, 1'b1, 1'b0, 1'b0, "chain_grant");
    period(1'b1, 1'b0, 1'b0, 1'b0, "chain_ext");
    period(1'b1, 1'b0, 1'b0, 1'b0, "chain_reclaim");
    period(1'b1, 1'b1, 1'b0, 1'b0, "chain_regrant");
    period(1'b1, 1'b1, 1'b0, 1'b0, "chain_ext2");

    // Reset while an external master owns the bus.
    reset_now("reset_ext");
    period(1'b0, 1'b0, 1'b0, 1'b0, "post_reset");

    // External tenure ending with a Pi transaction pending, then a new BR.
    period(1'b1, 1'b0, 1'b0, 1'b1, "fair_req");
    period(1'b1, 1'b1, 1'b0, 1'b1, "fair_grant");
    period(1'b0, 1'b0, 1'b0, 1'b1, "fair_ext");
    period(1'b0, 1'b0, 1'b0, 1'b1, "fair_reclaim");
    period(1'b1, 1'b0, 1'b0, 1'b1, "fair_own");
    period(1'b1, 1'b0, 1'b1, 1'b1, "fair_br");
    period(1'b1, 1'b0, 1'b0, 1'b0, "fair_cyc");
    period(1'b1, 1'b0, 1'b0, 1'b0, "fair_after");
    period(1'b0, 1'b0, 1'b0, 1'b0, "fair_rel");
    period(1'b0, 1'b0, 1'b0, 1'b0, "fair_idle");

    // Randomized traffic; BGACK is likelier while the model offers/holds a grant.
    for (int i = 0; i < 400; i++) begin
      bit br, ba, cy, op;
      br = ($urandom_range(0, 99) < 60);
      if (holder == H_OFFER || holder == H_DMA) ba = ($urandom_range(0, 99) < 70);
      else ba = ($urandom_range(0, 99) < 10);
      cy = ($urandom_range(0, 99) < 30);
      op = ($urandom_range(0, 99) < 50);
      period(br, ba, cy, op, "rand");
      if (i == 200) reset_now("rand_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
